// File: rtl/usb_line_frontend_if.sv
// SIE-side bus of the USB line front end: the transmit request and data go in,
// and the conditioned receive pair, the line state and the bus-reset flag come back.
interface usb_line_frontend_if;
    logic       OUT_EN;
    logic       dataOutP;
    logic       dataOutN;
    logic       dataInP;
    logic       dataInN;
    logic [1:0] lineState;
    logic       usbReset;

    modport master (
        output OUT_EN, dataOutP, dataOutN,
        input  dataInP, dataInN, lineState, usbReset
    );

    modport slave (
        input  OUT_EN, dataOutP, dataOutN,
        output dataInP, dataInN, lineState, usbReset
    );
endinterface

// File: rtl/usb_line_frontend.sv
// USB full-speed line front end: pad synchronisers, an optional glitch filter (USB_LINE_GLITCH_FILTER_EN),
// receive masking across bus turnaround, line-state and bus-reset decode, and registered pad drive.
module usb_line_frontend #(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned FILTER_LEN        = 3,
    parameter int unsigned TURNAROUND_CYCLES = 4,
    parameter int unsigned RESET_CYCLES      = 120
) (
    input  logic               clk48,
    input  logic               rst_n,
    input  logic               pinP_IN,
    input  logic               pinN_IN,
    output logic               pinP_OUT,
    output logic               pinN_OUT,
    output logic               pinOE,
    usb_line_frontend_if.slave sie
);
    localparam int unsigned TURN_W = 4;
    localparam int unsigned SE0_W  = $clog2(RESET_CYCLES + 1);

    // Pairs are packed {N, P}, so a pair value equals its lineState code.
    localparam logic [1:0] LS_SE0 = 2'd0;
    localparam logic [1:0] LS_J   = 2'd1;

    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND_CYCLES);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(RESET_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gBadSyncStages
        $error("usb_line_frontend: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 8) begin : gBadFilterLen
        $error("usb_line_frontend: FILTER_LEN must be 1..8");
    end
    if (TURNAROUND_CYCLES > 15) begin : gBadTurnaround
        $error("usb_line_frontend: TURNAROUND_CYCLES must be 0..15");
    end
    if (RESET_CYCLES < 2 || RESET_CYCLES > 4095) begin : gBadResetCycles
        $error("usb_line_frontend: RESET_CYCLES must be 2..4095");
    end

    logic [SYNC_STAGES-1:0] syncP;
    logic [SYNC_STAGES-1:0] syncN;
    logic [1:0]             syncPair;
    logic [1:0]             rxPair;

    // Metastability chains; they reset to the idle J level so nothing spurious leaks out of reset.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            syncP <= '1;
            syncN <= '0;
        end else begin
            syncP <= {syncP[SYNC_STAGES-2:0], pinP_IN};
            syncN <= {syncN[SYNC_STAGES-2:0], pinN_IN};
        end
    end

    assign syncPair = {syncN[SYNC_STAGES-1], syncP[SYNC_STAGES-1]};

`ifdef USB_LINE_GLITCH_FILTER_EN
    localparam int unsigned        FILT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0]  FILT_MAX = FILT_W'(FILTER_LEN);

    logic [1:0]        lastPair;
    logic [1:0]        filtPair;
    logic [FILT_W-1:0] stableCnt;
    logic [FILT_W-1:0] heldCnt_c;

    // Cycles the synchronised pair has held its value, counting the current cycle.
    always_comb begin
        heldCnt_c = FILT_W'(1);
        if (syncPair == lastPair) begin
            heldCnt_c = (stableCnt == FILT_MAX) ? FILT_MAX : stableCnt + FILT_W'(1);
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            lastPair  <= LS_J;
            filtPair  <= LS_J;
            stableCnt <= '0;
        end else begin
            lastPair  <= syncPair;
            stableCnt <= heldCnt_c;
            if (heldCnt_c == FILT_MAX) begin
                filtPair <= syncPair;
            end
        end
    end

    assign rxPair = filtPair;
`else
    assign rxPair = syncPair;
`endif

    logic [TURN_W-1:0] turnCnt;
    logic              maskRx_c;
    logic [1:0]        maskedPair_c;
    logic [1:0]        lineStateReg;

    // Our own transmission echoes back on the pads, so receive is held at J until the bus has turned around.
    assign maskRx_c     = sie.OUT_EN || (turnCnt != '0);
    assign maskedPair_c = maskRx_c ? LS_J : rxPair;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            turnCnt      <= '0;
            lineStateReg <= LS_J;
        end else begin
            if (sie.OUT_EN) begin
                turnCnt <= TURN_LOAD;
            end else if (turnCnt != '0) begin
                turnCnt <= turnCnt - TURN_W'(1);
            end
            lineStateReg <= maskedPair_c;
        end
    end

    logic [SE0_W-1:0] se0Cnt;
    logic             usbResetReg;

    // Bus reset: RESET_CYCLES consecutive SE0 cycles; any other line state clears the run.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            se0Cnt      <= '0;
            usbResetReg <= 1'b0;
        end else if (lineStateReg == LS_SE0) begin
            if (se0Cnt != SE0_MAX) begin
                se0Cnt <= se0Cnt + SE0_W'(1);
            end
            usbResetReg <= (se0Cnt == SE0_MAX);
        end else begin
            se0Cnt      <= '0;
            usbResetReg <= 1'b0;
        end
    end

    // Pad drive; the idle drive level is J so enabling the buffer never glitches the bus.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            pinOE    <= 1'b0;
            pinP_OUT <= 1'b1;
            pinN_OUT <= 1'b0;
        end else begin
            pinOE    <= sie.OUT_EN;
            pinP_OUT <= sie.OUT_EN ? sie.dataOutP : 1'b1;
            pinN_OUT <= sie.OUT_EN ? sie.dataOutN : 1'b0;
        end
    end

    assign sie.dataInP   = lineStateReg[0];
    assign sie.dataInN   = lineStateReg[1];
    assign sie.lineState = lineStateReg;
    assign sie.usbReset  = usbResetReg;
endmodule

// File: doc/usb_line_frontend.md
USB_LINE_FRONTEND -- requirements
Module: usb_line_frontend

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops per line (legal 2..4).
REQ-002 Parameter FILTER_LEN, default 3, consecutive stable cycles required before a line change is accepted (legal 1..8).
REQ-003 Parameter TURNAROUND_CYCLES, default 4, cycles the receive path stays masked after OUT_EN falls (legal 0..15).
REQ-004 Parameter RESET_CYCLES, default 120, consecutive SE0 cycles that signal a bus reset (legal 2..4095).
REQ-005 Port clk48  input  1  sole clock, 48 MHz.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port pinP_IN / pinN_IN  input  1 each  raw, asynchronous pad inputs.
REQ-008 Port pinP_OUT / pinN_OUT  output  1 each  registered pad drive values.
REQ-009 Port pinOE  output  1  registered pad output enable; the tristate buffer lives outside this block.
REQ-010 Port OUT_EN / dataOutP / dataOutN  input  1 each  transmit request and transmit data.
REQ-011 Port dataInP / dataInN  output  1 each  synchronised, filtered and masked receive data.
REQ-012 Port lineState  output  2  decoded line state: 0=SE0, 1=J, 2=K, 3=SE1.
REQ-013 Port usbReset  output  1  level high while a bus reset condition is present.

Function
REQ-014 Each pad input SHALL pass through a SYNC_STAGES-deep flop chain; the P chain resets to 1 and the N chain resets to 0.
REQ-015 The filter SHALL load the synchronised pair only after it has held the same value for FILTER_LEN consecutive cycles; any change restarts the counter, and the counter saturates.
REQ-016 While OUT_EN=1, and for TURNAROUND_CYCLES cycles after OUT_EN falls, dataInP/dataInN SHALL be forced to 1/0 (J).
REQ-017 If OUT_EN rises again during turnaround, the turnaround counter SHALL reload, and masking SHALL continue until TURNAROUND_CYCLES cycles after the new falling edge.
REQ-018 With OUT_EN=0 and turnaround expired, dataInP/dataInN SHALL follow the filter output registered once.
REQ-019 End-to-end latency for an unmasked line change:
- SYNC_STAGES+FILTER_LEN+1 cycles with the filter;
- SYNC_STAGES+1 cycles without it.
REQ-020 lineState SHALL be a registered decode of the masked pair, updated in the same cycle as dataInP/dataInN.
REQ-021 The SE0 counter SHALL increment on each cycle with masked lineState=SE0, saturate at RESET_CYCLES, and clear on any other state.
REQ-022 usbReset SHALL assert in the cycle after the counter reaches RESET_CYCLES and deassert in the cycle after the first non-SE0 lineState.
REQ-023 SE1 SHALL never increment the SE0 counter.
REQ-024 pinOE, pinP_OUT and pinN_OUT SHALL register OUT_EN, dataOutP and dataOutN with one cycle of latency.
REQ-025 While OUT_EN=0, pinP_OUT/pinN_OUT SHALL hold 1/0.

Reset
REQ-026 On rst_n=0, all flops SHALL be forced immediately (asynchronously) as follows:
- dataInP=1, dataInN=0, lineState=1 (J);
- usbReset=0, pinOE=0, pinP_OUT=1, pinN_OUT=0;
- all counters cleared, turnaround inactive.
REQ-027 Reset asserted mid-transmit or mid-SE0 SHALL abort the operation with no residual state; release SHALL be synchronous to clk48.

Configuration
REQ-028 Macro USB_LINE_GLITCH_FILTER_EN:
- defined: the REQ-015 filter is instantiated;
- undefined: the filter is removed, and the synchroniser output feeds the masking stage directly.
REQ-029 Parameter FILTER_LEN SHALL be ignored when USB_LINE_GLITCH_FILTER_EN is undefined.

Verification
REQ-030 Defaults, filter enabled: drive P/N 10->01 and hold -> dataInP/dataInN = 0/1 and lineState=2 exactly 6 cycles after the change.
REQ-031 Filter enabled: 2-cycle K glitch on an idle J line -> dataInP/dataInN stay 1/0 and lineState stays 1 throughout.
REQ-032 Hold SE0 for 130 cycles, then J -> usbReset rises at the 121st cycle after masked SE0 onset and falls 1 cycle after lineState returns to J.
REQ-033 Pulse OUT_EN for 10 cycles while the pads show K -> dataInP/dataInN = 1/0 during OUT_EN and for 4 further cycles, then K reappears after REQ-018 latency; pinOE is high for exactly cycles 1..10 (one cycle delayed).
REQ-034 Assert rst_n=0 at cycle 60 of a 130-cycle SE0 hold -> usbReset=0 and lineState=1 immediately; after release the count restarts from 0 and usbReset asserts only after a further 120 masked SE0 cycles.
REQ-035 Filter disabled, SYNC_STAGES=3: a 1-cycle glitch propagates to dataInP 4 cycles later.
